// File: rtl/spi_controller.sv
// Memory-mapped SPI master (mode 0, 8-bit frames) for the yarvi SPI window.
// DATA register shifts a byte out/in; CTRL/STATUS sets divider, chip select and reports flags.
module spi_controller #(
    parameter logic [7:0] DIV_RESET = 8'd3
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        rw,
    input  logic        writeenable,
    input  logic [31:0] writedata,
    input  logic        readenable,
    output logic [31:0] readdata,
    output logic        sclk,
    output logic        mosi,
    input  logic        miso,
    output logic        cs_n
);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_HIGH  = 3'd2,
        ST_LOW   = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic [7:0]  div_q, div_d;
    logic [7:0]  cur_div_q, cur_div_d;
    logic [7:0]  hcnt_q, hcnt_d;
    logic [2:0]  bitcnt_q, bitcnt_d;
    logic [7:0]  shift_q, shift_d;
    logic [7:0]  rx_byte_q, rx_byte_d;
    logic        rx_valid_q, rx_valid_d;
    logic        overrun_q, overrun_d;
    logic        sclk_q, sclk_d;
    logic        mosi_q, mosi_d;
    logic        cs_n_q, cs_n_d;
    logic [31:0] rdata_q, rdata_d;

    logic data_wr_s, ctrl_wr_s, data_rd_s, stat_rd_s, busy_s, half_end_s;

    assign data_wr_s  = writeenable & ~rw;
    assign ctrl_wr_s  = writeenable & rw;
    assign data_rd_s  = readenable & ~rw;
    assign stat_rd_s  = readenable & rw;
    assign busy_s     = (state_q != ST_IDLE);
    // The divider is latched per half-period so a CTRL write never strands the counter.
    assign half_end_s = (hcnt_q == cur_div_q);

    assign readdata = rdata_q;
    assign sclk     = sclk_q;
    assign mosi     = mosi_q;
    assign cs_n     = cs_n_q;

    // Next-state logic for the transfer FSM, register file and read bus.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        cur_div_d  = cur_div_q;
        hcnt_d     = hcnt_q;
        bitcnt_d   = bitcnt_q;
        shift_d    = shift_q;
        rx_byte_d  = rx_byte_q;
        rx_valid_d = rx_valid_q;
        overrun_d  = overrun_q;
        sclk_d     = sclk_q;
        mosi_d     = mosi_q;
        cs_n_d     = cs_n_q;
        rdata_d    = 32'h0000_0000;

        if (stat_rd_s) begin
            rdata_d = {16'h0000, div_q, 5'b00000, overrun_q, rx_valid_q, busy_s};
        end else if (data_rd_s) begin
            rdata_d = {24'h00_0000, rx_byte_q};
        end else begin
            rdata_d = 32'h0000_0000;
        end

        if (ctrl_wr_s) begin
            div_d  = writedata[7:0];
            cs_n_d = ~writedata[8];
        end else begin
            div_d  = div_q;
            cs_n_d = cs_n_q;
        end

        if (data_wr_s && busy_s) begin
            overrun_d = 1'b1;
        end else if (stat_rd_s) begin
            overrun_d = 1'b0;
        end else begin
            overrun_d = overrun_q;
        end

        if (state_q == ST_DONE) begin
            rx_valid_d = 1'b1;
        end else if (data_rd_s) begin
            rx_valid_d = 1'b0;
        end else begin
            rx_valid_d = rx_valid_q;
        end

        case (state_q)
            ST_IDLE: begin
                sclk_d = 1'b0;
                if (data_wr_s) begin
                    shift_d   = writedata[7:0];
                    mosi_d    = writedata[7];
                    bitcnt_d  = 3'd0;
                    hcnt_d    = 8'd0;
                    cur_div_d = div_q;
                    state_d   = ST_SETUP;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_SETUP, ST_LOW: begin
                if (half_end_s) begin
                    sclk_d    = 1'b1;
                    shift_d   = {shift_q[6:0], miso};
                    hcnt_d    = 8'd0;
                    cur_div_d = div_q;
                    state_d   = ST_HIGH;
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            ST_HIGH: begin
                if (half_end_s) begin
                    sclk_d    = 1'b0;
                    hcnt_d    = 8'd0;
                    cur_div_d = div_q;
                    if (bitcnt_q == 3'd7) begin
                        state_d = ST_DONE;
                    end else begin
                        // shift_q[7] already holds the next bit after the sampling shift.
                        bitcnt_d = bitcnt_q + 3'd1;
                        mosi_d   = shift_q[7];
                        state_d  = ST_LOW;
                    end
                end else begin
                    hcnt_d = hcnt_q + 8'd1;
                end
            end
            ST_DONE: begin
                rx_byte_d = shift_q;
                state_d   = ST_IDLE;
            end
            default: begin
                sclk_d  = 1'b0;
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q    <= ST_IDLE;
            div_q      <= DIV_RESET;
            cur_div_q  <= DIV_RESET;
            hcnt_q     <= 8'd0;
            bitcnt_q   <= 3'd0;
            shift_q    <= 8'd0;
            rx_byte_q  <= 8'd0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
            sclk_q     <= 1'b0;
            mosi_q     <= 1'b0;
            cs_n_q     <= 1'b1;
            rdata_q    <= 32'h0000_0000;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            cur_div_q  <= cur_div_d;
            hcnt_q     <= hcnt_d;
            bitcnt_q   <= bitcnt_d;
            shift_q    <= shift_d;
            rx_byte_q  <= rx_byte_d;
            rx_valid_q <= rx_valid_d;
            overrun_q  <= overrun_d;
            sclk_q     <= sclk_d;
            mosi_q     <= mosi_d;
            cs_n_q     <= cs_n_d;
            rdata_q    <= rdata_d;
        end
    end

endmodule

// File: tb/tb_spi_controller.sv
// Bench for spi_controller: behavioural SPI slave plus a register-level model of the controller.
module tb_spi_controller;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        rw;
    logic        writeenable;
    logic [31:0] writedata;
    logic        readenable;
    logic [31:0] readdata;
    logic        sclk, mosi, miso, cs_n;

    int n_cmp  = 0;
    int n_fail = 0;

    // Register-level model state
    logic [7:0] m_div;
    logic       m_cs_n, m_rxv, m_ovr;
    logic [7:0] m_rx;

    // Slave model: shifts slave_pat out MSB first (or echoes mosi), captures mosi on sclk rises
    logic       slave_loop = 1'b1;
    logic [7:0] slave_pat  = 8'h00;
    logic       slave_rst  = 1'b1;
    logic       sclk_prev  = 1'b0;
    logic [3:0] slave_idx;
    logic [7:0] mosi_cap;
    int hi_run, lo_run, hi_min, hi_max, lo_min, lo_max;

    spi_controller #(.DIV_RESET(8'd3)) dut (
        .clk(clk), .reset_n(reset_n), .rw(rw), .writeenable(writeenable),
        .writedata(writedata), .readenable(readenable), .readdata(readdata),
        .sclk(sclk), .mosi(mosi), .miso(miso), .cs_n(cs_n)
    );

    always #5 clk = ~clk;

    assign miso = slave_loop ? mosi : slave_pat[~slave_idx[2:0]];

    always @(posedge clk) begin
        sclk_prev <= sclk;
        if (slave_rst) begin
            slave_idx <= 4'd0; mosi_cap <= 8'h00;
            hi_run <= 0; lo_run <= 0;
            hi_min <= 9999; hi_max <= 0; lo_min <= 9999; lo_max <= 0;
        end else if (sclk) begin
            if (!sclk_prev) begin
                slave_idx <= slave_idx + 4'd1;
                mosi_cap  <= {mosi_cap[6:0], mosi};
                hi_run    <= 1;
                if (slave_idx != 4'd0) begin
                    if (lo_run < lo_min) lo_min <= lo_run;
                    if (lo_run > lo_max) lo_max <= lo_run;
                end
            end else begin
                hi_run <= hi_run + 1;
            end
        end else begin
            if (sclk_prev) begin
                if (hi_run < hi_min) hi_min <= hi_run;
                if (hi_run > hi_max) hi_max <= hi_run;
                lo_run <= 1;
            end else begin
                lo_run <= lo_run + 1;
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic bus_write(input logic sel, input logic [31:0] data);
        rw = sel; writedata = data; writeenable = 1'b1;
        tick();
        writeenable = 1'b0;
        if (sel) begin
            m_div = data[7:0];
            m_cs_n = ~data[8];
        end else if (!m_rxv && 1'b0) begin
            m_ovr = 1'b0;
        end
    endtask

    task automatic bus_read(input logic sel, output logic [31:0] data);
        rw = sel; readenable = 1'b1;
        tick();
        readenable = 1'b0;
        data = readdata;
    endtask

    task automatic rd_status_check(input string tag);
        logic [31:0] d;
        bus_read(1'b1, d);
        check(tag, d, {16'h0000, m_div, 5'b00000, m_ovr, m_rxv, 1'b0});
        m_ovr = 1'b0;
    endtask

    task automatic rd_data_check(input string tag);
        logic [31:0] d;
        bus_read(1'b0, d);
        check(tag, d, {24'h00_0000, m_rx});
        m_rxv = 1'b0;
    endtask

    task automatic slave_prep(input logic [7:0] pat, input logic loop);
        slave_loop = loop; slave_pat = pat; slave_rst = 1'b1;
        tick();
        slave_rst = 1'b0;
    endtask

    // Full frame: start, poll STATUS every cycle, then check timing and shifted data
    task automatic run_xfer(input string tag, input logic [7:0] tx, input logic [7:0] pat,
                            input logic loop);
        int  n;
        logic done;
        int  half;
        half = int'(m_div) + 1;
        slave_prep(pat, loop);
        bus_write(1'b0, {24'h00_0000, tx});
        n = 0; done = 1'b0;
        rw = 1'b1; readenable = 1'b1;
        for (int k = 0; k < 3000; k++) begin
            tick();
            if (readdata[0] !== 1'b1) begin
                done = 1'b1;
                break;
            end
            n++;
        end
        readenable = 1'b0;
        m_ovr = 1'b0;
        check({tag, "_done"}, 32'(done), 32'd1);
        check({tag, "_busy_len"}, n, 16 * half + 1);
        check({tag, "_pulses"}, 32'(slave_idx), 32'd8);
        check({tag, "_mosi"}, 32'(mosi_cap), 32'(tx));
        check({tag, "_hi_min"}, hi_min, half);
        check({tag, "_hi_max"}, hi_max, half);
        check({tag, "_lo_max"}, lo_max, half);
        m_rx  = loop ? tx : pat;
        m_rxv = 1'b1;
    endtask

    initial begin
        logic [31:0] d;
        logic [7:0]  tx, pat, b1, b2;
        logic [7:0]  dv;
        logic        lp, found;
        int          frame;

        reset_n = 1'b0; rw = 1'b0; writeenable = 1'b0; writedata = 32'h0; readenable = 1'b0;
        m_div = 8'd3; m_cs_n = 1'b1; m_rxv = 1'b0; m_ovr = 1'b0; m_rx = 8'h00;
        tick(); tick();
        check("rst_sclk", 32'(sclk), 32'd0);
        check("rst_mosi", 32'(mosi), 32'd0);
        check("rst_cs_n", 32'(cs_n), 32'd1);
        check("rst_readdata", readdata, 32'h0);
        reset_n = 1'b1;
        slave_rst = 1'b0;
        bus_read(1'b1, d);
        check("rst_status", d, 32'h0000_0300);
        tick();
        check("rd_idle_zero", readdata, 32'h0);

        // Loopback at the fastest rate
        bus_write(1'b1, 32'h0000_0100);
        check("cs_assert", 32'(cs_n), 32'd0);
        run_xfer("loop_a5", 8'hA5, 8'h00, 1'b1);
        rd_status_check("loop_status");
        check("loop_status_lit", {16'h0, m_div, 8'h00}, 32'h0);
        rd_data_check("loop_data");
        rd_status_check("loop_status2");

        // div=3 with the slave driving 0x3C
        bus_write(1'b1, 32'h0000_0103);
        tx = 8'($urandom);
        run_xfer("div3", tx, 8'h3C, 1'b0);
        rd_data_check("div3_data");

        // Overrun: second DATA write mid-frame is dropped
        slave_prep(8'h00, 1'b1);
        bus_write(1'b0, 32'h0000_0011);
        for (int k = 0; k < 9; k++) tick();
        bus_write(1'b0, 32'h0000_0022);
        m_ovr = 1'b1;
        for (int k = 0; k < 60; k++) tick();
        m_rx = 8'h11; m_rxv = 1'b1;
        check("ovr_mosi", 32'(mosi_cap), 32'h11);
        check("ovr_pulses", 32'(slave_idx), 32'd8);
        rd_status_check("ovr_status_set");
        rd_status_check("ovr_status_clr");
        rd_data_check("ovr_data");

        // Reset in the middle of a frame
        bus_write(1'b1, 32'h0000_0100);
        slave_prep(8'h00, 1'b1);
        bus_write(1'b0, {24'h0, 8'($urandom)});
        found = 1'b0;
        for (int k = 0; k < 200; k++) begin
            if (slave_idx >= 4'd4) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("midrst_reached_bit4", 32'(found), 32'd1);
        reset_n = 1'b0;
        tick();
        reset_n = 1'b1;
        m_div = 8'd3; m_cs_n = 1'b1; m_rxv = 1'b0; m_ovr = 1'b0; m_rx = 8'h00;
        check("midrst_sclk", 32'(sclk), 32'd0);
        check("midrst_cs_n", 32'(cs_n), 32'd1);
        check("midrst_readdata", readdata, 32'h0);
        rd_status_check("midrst_status");
        bus_write(1'b1, 32'h0000_0100);
        run_xfer("after_rst_ff", 8'hFF, 8'h00, 1'b1);
        rd_data_check("after_rst_data");

        // Read-bus hygiene: one-cycle pulse
        bus_read(1'b1, d);
        check("pulse_status", d, {16'h0, m_div, 5'b0, m_ovr, m_rxv, 1'b0});
        tick();
        check("pulse_then_zero", readdata, 32'h0);

        // Completion coincides with a DATA read
        dv = 8'($urandom_range(0, 3));
        bus_write(1'b1, {23'h0, 1'b1, dv});
        b1 = 8'($urandom); b2 = 8'($urandom);
        run_xfer("pre_coinc", b1, 8'h00, 1'b1);
        slave_prep(8'h00, 1'b1);
        frame = 16 * (int'(dv) + 1) + 1;
        bus_write(1'b0, {24'h0, b2});
        for (int k = 0; k < frame - 1; k++) tick();
        bus_read(1'b0, d);
        check("coinc_old_byte", d, {24'h0, b1});
        m_rx = b2; m_rxv = 1'b1;
        rd_status_check("coinc_rxv_set");
        rd_data_check("coinc_new_byte");

        // Randomized frames against the model
        for (int it = 0; it < 6; it++) begin
            dv  = 8'($urandom_range(0, 3));
            tx  = 8'($urandom);
            pat = 8'($urandom);
            lp  = 1'($urandom);
            bus_write(1'b1, {23'h0, 1'($urandom), dv});
            check("rnd_cs_n", 32'(cs_n), 32'(m_cs_n));
            run_xfer("rnd", tx, pat, lp);
            rd_status_check("rnd_status");
            rd_data_check("rnd_data");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_controller.md
Name: spi_controller

Overview:
- Memory-mapped SPI master (mode 0, 8-bit frames) that decodes the `SPI` window (address[29:22] = 0x82) of the yarvi data bus.
- Takes gated writeenable/readenable from the SoC top and drives sclk/mosi/cs_n to an external SPI flash or SD card.
- Returns register data on readdata with one cycle of latency. readdata is forced to zero when idle, so the SoC can OR it with the uart/gpio read paths.

Parameters:
- DIV_RESET, 8'd3, reset value of the clock divider. SCLK half-period = (div+1) clk cycles.

Ports:
- clk  input  1  system clock
- reset_n  input  1  synchronous reset, active low
- rw  input  1  register select (address[0]): 0 = DATA, 1 = CTRL/STATUS
- writeenable  input  1  bus write strobe, already gated by the SPI window decode
- writedata  input  32  bus write data
- readenable  input  1  bus read strobe, already gated by the SPI window decode
- readdata  output  32  registered read data, valid the cycle after readenable
- sclk  output  1  SPI clock, idles low
- mosi  output  1  SPI data out, MSB first
- miso  input  1  SPI data in
- cs_n  output  1  chip select, software controlled, active low

Behaviour:
- Reset (reset_n=0 at a clk edge) sets:
  - sclk=0, mosi=0, cs_n=1, readdata=0
  - div=DIV_RESET, state=IDLE
  - rx_byte=0, rx_valid=0, overrun=0, bit counter=0
  - Reset mid-transfer aborts immediately. No completion flag is raised.
- Registers:
  - DATA write: starts a transfer of writedata[7:0] if state=IDLE. If a transfer is in progress, the write is dropped and overrun is set.
  - DATA read: returns {24'b0, rx_byte} and clears rx_valid.
  - CTRL write: div <= writedata[7:0]; cs_n <= ~writedata[8]. Accepted in any state; a new div takes effect at the next half-period boundary.
  - STATUS read: returns {16'b0, div, 5'b0, overrun, rx_valid, busy}, busy = (state != IDLE). The read clears overrun.
- readdata:
  - Loaded on the clk edge where readenable=1.
  - Is 0 on every cycle following a cycle with readenable=0.
  - writeenable and readenable asserted together: both actions occur.
- FSM: IDLE -> SETUP -> HIGH -> LOW -> ... -> DONE -> IDLE.
  - IDLE: sclk=0. On a DATA write, load shift register = writedata[7:0], drive mosi = bit7, set bitcnt=0, start the half-period counter at 0, go to SETUP.
  - SETUP: wait div+1 cycles with sclk=0, then go to HIGH.
  - HIGH: sclk=1. On entry, sample miso into shift register bit0 (shift left). Hold div+1 cycles, then go to LOW.
  - LOW: sclk=0. On entry, if bitcnt=7 go to DONE; otherwise bitcnt+1 and drive mosi = next bit. Hold div+1 cycles, then go to HIGH.
  - DONE (1 cycle): rx_byte <= shift register, rx_valid=1, then IDLE.
  - Frame length = 1 + 16*(div+1) clk cycles from the write edge to busy=0.
- div=0 gives SCLK = clk/2, the fastest rate.
- Completion and a DATA read in the same cycle: the read returns the old rx_byte, and rx_valid ends at 1 (set wins over clear).
- DATA write in the DONE cycle counts as busy, so it is dropped and sets overrun.
- cs_n is never toggled by the FSM. Software must assert it before the first DATA write.

Test Plan:
- Reset: hold reset_n=0 for 2 cycles -> sclk=0, cs_n=1, readdata=0; STATUS read returns 0x00000300 (div=3, all flags 0).
- Loopback (miso tied to mosi), CTRL write 0x100 (div=0, cs_n=0), DATA write 0xA5 -> 8 sclk pulses, busy for 17 cycles, mosi sequence 1,0,1,0,0,1,0,1; STATUS=0x00000002; DATA read=0x000000A5; next STATUS=0x00000000.
- div=3, miso driven with pattern 0x3C by the bench -> each sclk high/low lasts 4 cycles, busy for 65 cycles, DATA read=0x3C.
- Overrun: DATA write 0x11, then DATA write 0x22 mid-frame -> only 0x11 shifted out; STATUS bit2=1; a second STATUS read shows bit2=0.
- Reset mid-frame: assert reset_n=0 at bit 4 -> the next cycle shows sclk=0, busy=0, rx_valid=0; a following transfer of 0xFF completes normally.
- Read-bus hygiene: readenable pulse on STATUS -> readdata nonzero for exactly one cycle, then 0; a simultaneous completion and DATA read returns the old byte and leaves rx_valid=1.
